// File: rtl/rtc_lectura_if.sv
`default_nettype none
// ============================================================================
// Module   : rtc_lectura_if
// Brief    : Control, RTC multiplexed bus and memory-copy signals of rtc_lectura.
// Revision : 1.0
// ============================================================================
interface rtc_lectura_if;
  logic       start;
  logic [7:0] AD_in;
  logic       actready;
  logic [7:0] AD_out;
  logic       AD_oe;
  logic       CS_n;
  logic       RD_n;
  logic       WR_n;
  logic       AD_sel;
  logic [3:0] ADD1;
  logic [7:0] DAT1;
  logic       w1;
  logic       whileT;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    input  start, AD_in, actready,
    output AD_out, AD_oe, CS_n, RD_n, WR_n, AD_sel,
    output ADD1, DAT1, w1, whileT, busy, done, err
  );

  modport slave (
    output start, AD_in, actready,
    input  AD_out, AD_oe, CS_n, RD_n, WR_n, AD_sel,
    input  ADD1, DAT1, w1, whileT, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/rtc_lectura.sv
`default_nettype none
// ============================================================================
// Module   : rtc_lectura
// Brief    : Reads the 9 RTC time/timer registers and copies them to memory slots.
// Revision : 1.0
// ============================================================================
module rtc_lectura #(
  parameter int T_PULSE = 4,
  parameter int T_ACT   = 64
) (
  input  logic          clk,
  input  logic          reset,
  rtc_lectura_if.master bus
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_ADDR   = 3'd1;
  localparam logic [2:0] c_GAP    = 3'd2;
  localparam logic [2:0] c_DATA   = 3'd3;
  localparam logic [2:0] c_WRMEM  = 3'd4;
  localparam logic [2:0] c_NEXT   = 3'd5;
  localparam logic [2:0] c_CIERRE = 3'd6;
  localparam logic [2:0] c_ESPERA = 3'd7;

  localparam logic [3:0] c_PH_LAST  = 4'(T_PULSE - 1);
  localparam logic [3:0] c_IDX_LAST = 4'd8;
  localparam logic [8:0] c_ACT_LIM  = 9'(T_ACT);

  logic [2:0] r_state;
  logic [3:0] r_idx;
  logic [3:0] r_ph_cnt;
  logic [7:0] r_act_cnt;
  logic [7:0] r_data;
  logic       r_done;
  logic       r_err;

  logic [7:0] w_addr;
  logic [3:0] w_slot;
  logic       w_ph_last;
  logic       w_act_expire;

  always_comb begin
    w_addr = 8'h00;
    w_slot = 4'd0;
    case (r_idx)
      4'd0:    begin w_addr = 8'h21; w_slot = 4'd1;  end
      4'd1:    begin w_addr = 8'h22; w_slot = 4'd2;  end
      4'd2:    begin w_addr = 8'h23; w_slot = 4'd3;  end
      4'd3:    begin w_addr = 8'h24; w_slot = 4'd4;  end
      4'd4:    begin w_addr = 8'h25; w_slot = 4'd5;  end
      4'd5:    begin w_addr = 8'h26; w_slot = 4'd6;  end
      4'd6:    begin w_addr = 8'h41; w_slot = 4'd9;  end
      4'd7:    begin w_addr = 8'h42; w_slot = 4'd10; end
      4'd8:    begin w_addr = 8'h43; w_slot = 4'd11; end
      default: begin w_addr = 8'h00; w_slot = 4'd0;  end
    endcase
  end

  assign w_ph_last = (r_ph_cnt == c_PH_LAST);
  // CIERRE is cycle 1 after whileT falls, so ESPERA cycle k is cycle k+1; expire at cycle T_ACT.
  assign w_act_expire = ({1'b0, r_act_cnt} + 9'd2) >= c_ACT_LIM;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= c_IDLE;
      r_idx     <= 4'd0;
      r_ph_cnt  <= 4'd0;
      r_act_cnt <= 8'd0;
      r_data    <= 8'h00;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (bus.start) begin
            r_state  <= c_ADDR;
            r_idx    <= 4'd0;
            r_ph_cnt <= 4'd0;
            r_err    <= 1'b0;
          end
        end
        c_ADDR: begin
          if (w_ph_last) begin
            r_state  <= c_GAP;
            r_ph_cnt <= 4'd0;
          end else begin
            r_ph_cnt <= r_ph_cnt + 4'd1;
          end
        end
        c_GAP: begin
          r_state  <= c_DATA;
          r_ph_cnt <= 4'd0;
        end
        c_DATA: begin
          if (w_ph_last) begin
            r_data   <= bus.AD_in;
            r_state  <= c_WRMEM;
            r_ph_cnt <= 4'd0;
          end else begin
            r_ph_cnt <= r_ph_cnt + 4'd1;
          end
        end
        c_WRMEM: r_state <= c_NEXT;
        c_NEXT: begin
          if (r_idx == c_IDX_LAST) begin
            r_state <= c_CIERRE;
          end else begin
            r_idx    <= r_idx + 4'd1;
            r_ph_cnt <= 4'd0;
            r_state  <= c_ADDR;
          end
        end
        c_CIERRE: begin
          r_act_cnt <= 8'd0;
          r_state   <= c_ESPERA;
        end
        c_ESPERA: begin
          if (bus.actready) begin
            r_state <= c_IDLE;
            r_done  <= 1'b1;
            r_err   <= 1'b0;
          end else if (w_act_expire) begin
            r_state <= c_IDLE;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end else begin
            r_act_cnt <= r_act_cnt + 8'd1;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign bus.CS_n   = !((r_state == c_ADDR) || (r_state == c_GAP) || (r_state == c_DATA));
  assign bus.WR_n   = (r_state != c_ADDR);
  assign bus.RD_n   = (r_state != c_DATA);
  assign bus.AD_sel = (r_state == c_DATA);
  assign bus.AD_oe  = (r_state == c_ADDR);
  assign bus.AD_out = (r_state == c_ADDR) ? w_addr : 8'h00;

  assign bus.w1     = (r_state == c_WRMEM);
  assign bus.ADD1   = (r_state == c_WRMEM) ? w_slot : 4'd0;
  assign bus.DAT1   = (r_state == c_WRMEM) ? r_data : 8'h00;
  assign bus.whileT = (r_state == c_ADDR) || (r_state == c_GAP) || (r_state == c_DATA) ||
                      (r_state == c_WRMEM) || (r_state == c_NEXT);
  assign bus.busy   = (r_state != c_IDLE);
  assign bus.done   = r_done;
  assign bus.err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rtc_lectura.sv
`default_nettype none
// ============================================================================
// Module   : tb_rtc_lectura
// Brief    : Randomized scoreboard bench for rtc_lectura with RTC and memory models.
// Revision : 1.0
// ============================================================================
module tb_rtc_lectura;

  localparam int T_PULSE = 4;
  localparam int T_ACT   = 64;

  typedef struct packed {
    logic [3:0] slot;
    logic [7:0] addr;
    logic [7:0] data;
  } ent_t;

  typedef struct packed {
    logic       err;
    logic [7:0] dly;   // actready delay after whileT falls; 0 = never
  } dn_t;

  localparam logic [29:0] c_RST_OUTS = {3'b111, 27'd0};

  logic clk = 1'b0;
  logic reset;
  rtc_lectura_if bus();

  rtc_lectura #(.T_PULSE(T_PULSE), .T_ACT(T_ACT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  logic [7:0] addr_tab [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
  logic [3:0] slot_tab [9] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd9, 4'd10, 4'd11};

  ent_t exp_q[$];
  dn_t  dn_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [7:0] rtc_key = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [29:0] outs();
    return {bus.CS_n, bus.RD_n, bus.WR_n, bus.AD_sel, bus.AD_oe, bus.AD_out, bus.w1,
            bus.ADD1, bus.DAT1, bus.whileT, bus.busy, bus.done, bus.err};
  endfunction

  // Monitor + RTC/memory models, all sampled on the falling edge
  int         cyc = 0;
  int         wr_run, rd_run, burst_w1, last_w1, fall_cyc, burst_start, act_at;
  logic       prev_wt, prev_done, act_pend, hold_err;
  logic [7:0] rtc_addr;
  ent_t       e;
  dn_t        d;
  int         lat;

  always @(negedge clk) begin
    logic [29:0] o;
    cyc++;
    o = outs();
    if (!reset) begin
      wr_run = 0; rd_run = 0; burst_w1 = 0; last_w1 = -1;
      prev_wt = 1'b0; prev_done = 1'b0; act_pend = 1'b0; hold_err = 1'b0;
      bus.actready = 1'b0;
      bus.AD_in    = 8'h00;
    end else begin
      if (bus.whileT && !prev_wt) begin
        burst_start = cyc; burst_w1 = 0; last_w1 = -1;
        check("err cleared at burst entry", 32'(bus.err), 32'd0);
      end
      if (!bus.busy) begin
        check("idle outputs", 32'(o[29:2]), 32'({3'b111, 25'd0}));
        if (!bus.done) check("err hold", 32'(bus.err), 32'(hold_err));
      end else if (bus.CS_n) begin
        check("bus released", 32'({bus.RD_n, bus.WR_n, bus.AD_sel, bus.AD_oe, bus.AD_out}), 32'(12'hC00));
      end
      if (!bus.w1) check("mem idle", 32'({bus.ADD1, bus.DAT1}), 32'd0);

      if (!bus.WR_n) begin
        wr_run++;
        rtc_addr = bus.AD_out;
        check("addr phase", 32'({bus.CS_n, bus.AD_sel, bus.AD_oe, bus.RD_n, bus.AD_out}),
              32'({4'b0011, (exp_q.size() > 0) ? exp_q[0].addr : 8'h00}));
      end else if (wr_run != 0) begin
        check("WR_n low width", 32'(wr_run), 32'(T_PULSE));
        wr_run = 0;
      end
      if (!bus.RD_n) begin
        rd_run++;
        check("data phase", 32'({bus.CS_n, bus.AD_sel, bus.AD_oe, bus.WR_n}), 32'(4'b0101));
      end else if (rd_run != 0) begin
        check("RD_n low width", 32'(rd_run), 32'(T_PULSE));
        rd_run = 0;
      end
      if (bus.busy && !bus.CS_n && bus.WR_n && bus.RD_n)
        check("gap phase", 32'({bus.AD_oe, bus.AD_sel}), 32'd0);
      // RTC only presents valid data once its access time (full strobe) has elapsed
      if (!bus.RD_n && rd_run == T_PULSE) bus.AD_in = rtc_addr ^ rtc_key;
      else                               bus.AD_in = 8'($urandom);

      if (bus.w1) begin
        check("w1 inside whileT", 32'(bus.whileT), 32'd1);
        if (last_w1 >= 0) check("w1 spacing", 32'(cyc - last_w1), 32'(2 * T_PULSE + 3));
        last_w1 = cyc;
        burst_w1++;
        check("w1 with entry pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("mem write slot/data", 32'({bus.ADD1, bus.DAT1}), 32'({e.slot, e.data}));
        end
      end

      if (!bus.whileT && prev_wt) begin
        fall_cyc = cyc;
        check("w1 pulses per burst", 32'(burst_w1), 32'd9);
        if (dn_q.size() != 0 && dn_q[0].dly != 8'd0) begin
          act_pend = 1'b1;
          act_at   = cyc + int'(dn_q[0].dly);
        end
      end
      if (act_pend && cyc == act_at) bus.actready = 1'b1;

      if (bus.done) begin
        check("done is one cycle", 32'(prev_done), 32'd0);
        check("done outside burst", 32'({bus.busy, bus.whileT}), 32'd0);
        check("done has record", 32'(dn_q.size() != 0), 32'd1);
        if (dn_q.size() != 0) begin
          d   = dn_q.pop_front();
          lat = (d.dly != 8'd0) ? int'(d.dly) + 1 : T_ACT;
          check("err at done", 32'(bus.err), 32'(d.err));
          check("done after whileT fall", 32'(cyc - fall_cyc), 32'(lat));
          check("burst length", 32'(cyc - burst_start), 32'(9 * (2 * T_PULSE + 3) + lat));
          hold_err = d.err;
        end
        bus.actready = 1'b0;
        act_pend     = 1'b0;
      end
      prev_wt   = bus.whileT;
      prev_done = bus.done;
    end
  end

  task automatic push_burst(input logic [7:0] key, input logic [7:0] dly);
    for (int i = 0; i < 9; i++)
      exp_q.push_back('{slot: slot_tab[i], addr: addr_tab[i], data: addr_tab[i] ^ key});
    dn_q.push_back('{err: (dly == 8'd0), dly: dly});
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (bus.busy && n < 1000);
    check("idle reached in time", 32'(bus.busy), 32'd0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (dn_q.size() != 0 && n < 1000) begin @(posedge clk); n++; end
    check("done arrives in time", 32'(dn_q.size()), 32'd0);
    if (dn_q.size() != 0) begin exp_q.delete(); dn_q.delete(); end
  endtask

  task automatic issue_burst(input logic [7:0] key, input logic [7:0] dly, input bit noise);
    wait_idle();
    #1;
    rtc_key = key;
    push_burst(key, dly);
    bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    if (noise) begin
      repeat ($urandom_range(5, 80)) @(posedge clk);
      #2;
      if (bus.busy) begin
        bus.start = 1'b1;
        @(posedge clk); #2;
        bus.start = 1'b0;
      end
    end
    wait_done();
  endtask

  initial begin
    int n;
    bus.start = 1'b0;
    reset     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", 32'(outs()), 32'(c_RST_OUTS));
    #1 reset = 1'b1;

    issue_burst(8'hFF, 8'd3, 1'b0);            // nominal
    issue_burst(8'($urandom), 8'd0, 1'b0);     // actready never comes
    issue_burst(8'($urandom), 8'd5, 1'b0);     // recovery clears err
    for (int i = 0; i < 6; i++)
      issue_burst(8'($urandom), ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 20)), 1'b1);

    // start held high: three back-to-back bursts
    wait_idle();
    #1;
    rtc_key = 8'($urandom);
    push_burst(rtc_key, 8'd0);
    push_burst(rtc_key, 8'd2);
    push_burst(rtc_key, 8'd1);
    bus.start = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (dn_q.size() > 1 && n < 2000);
    check("held start progresses", 32'(dn_q.size() <= 1), 32'd1);
    #1 bus.start = 1'b0;
    wait_done();

    // reset during DATA of index 4, then restart right after release
    wait_idle();
    #1;
    rtc_key = 8'($urandom);
    push_burst(rtc_key, 8'd4);
    bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!(burst_w1 == 4 && !bus.RD_n) && n < 500);
    check("reached DATA of index 4", 32'({burst_w1 == 4, bus.RD_n}), 32'(2'b10));
    #1 reset = 1'b0;
    exp_q.delete();
    dn_q.delete();
    @(posedge clk); #1;
    check("mid-burst reset outputs", 32'(outs()), 32'(c_RST_OUTS));
    #1;
    rtc_key = 8'($urandom);
    push_burst(rtc_key, 8'd2);
    reset     = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    check("start after reset release", 32'({bus.busy, bus.whileT, bus.CS_n, bus.WR_n}), 32'(4'b1100));
    #1 bus.start = 1'b0;
    wait_done();

    repeat (5) @(posedge clk);
    check("scoreboard drained", 32'(exp_q.size() + dn_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire
